nand_processor_gen: RTL and testbench
=====================================

Name: nand_processor_gen

Overview:
- Parametrised successor to the team's 1-bit NAND/branch processor.
- Each register is WORD_W bits wide; NAND applies bitwise across the word. Register counts, instruction memory depth and PC width are parameters.
- Adds a serial program loader with a bit-valid strobe, overflow detection, a HALT encoding, and an out-of-range-fetch rule.
- Sits between the pad-level inputs/outputs and the test harness, like its predecessor.

Parameters:
- WORD_W, 1: width of every data register, in bits.
- NUM_IN, 2: number of read-only input registers.
- NUM_OUT, 7: number of output registers.
- NUM_INT, 6: number of internal registers.
- ADDR_W, 4: register address width. Requires 1+NUM_IN+NUM_OUT+NUM_INT <= 2**ADDR_W.
- IMEM_DEPTH, 1000: number of instruction words.
- PC_W, 10: program counter width. Requires 2**PC_W >= IMEM_DEPTH.
- INSTR_W, derived as 1+3*ADDR_W: instruction length in bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_reg  in  NUM_IN*WORD_W  input registers; in_reg[k*WORD_W +: WORD_W] is input k.
- load_en  in  1  1 = loader mode (core stalled); 0 = run.
- load_valid  in  1  qualifies load_bit for one cycle.
- load_bit  in  1  serial instruction bit, instruction bit 0 first.
- out_reg  out  NUM_OUT*WORD_W  output registers.
- pc  out  PC_W  current program counter.
- halted  out  1  core has executed HALT.
- load_overflow  out  1  sticky: program exceeded IMEM_DEPTH.

Behaviour:
- Reset: out_reg=0, internal regs=0, pc=0, halted=0, load_overflow=0, loader counters=0, imem all zero.
- Register map:
  - addr 0 = constant all-ones.
  - 1..NUM_IN = inputs.
  - next NUM_OUT = outputs.
  - next NUM_INT = internals.
  - Unmapped addresses read 0.
  - Writes to const, input or unmapped addresses are dropped.
- Instruction fields:
  - bit0 = op.
  - [ADDR_W:1] = srcA.
  - op=1 NAND: [2*ADDR_W:ADDR_W+1] = srcB; [3*ADDR_W:2*ADDR_W+1] = dst.
  - op=0 BRANCH: bits [3*ADDR_W:ADDR_W+1] form the offset field; MSB = dir (1 = backward), rest = magnitude M.
- Execution (load_en=0, halted=0): one instruction per cycle, fetch combinational from imem[pc].
  - NAND: dst <= ~(A & B); pc <= pc+1.
  - BRANCH with A != 0 and M != 0: pc <= pc ± M, modulo 2**PC_W. With A == 0: pc <= pc+1.
  - BRANCH with A != 0 and M == 0 is HALT: halted <= 1, pc holds.
- Halted: pc and all registers are frozen until reset or the end of a load.
- Out-of-range fetch: pc >= IMEM_DEPTH fetches all-zero, which decodes as HALT. Empty memory therefore halts at pc 0 in one cycle.
- Loader, while load_en=1:
  - Core is frozen (no register writes, pc held).
  - Each load_valid cycle writes load_bit into bit bit_cnt of the shift word; bit_cnt increments.
  - At bit_cnt = INSTR_W-1, the completed word is written to imem[wr_ptr] that cycle; wr_ptr++ and bit_cnt=0.
  - With wr_ptr == IMEM_DEPTH, further valid bits are dropped and load_overflow is set (sticky until reset).
- Load edges (load_en registered internally):
  - Rising edge: clears bit_cnt, wr_ptr and load_overflow. The first valid bit may arrive in the same cycle.
  - Falling edge: a partial word is discarded; pc <= 0 and halted <= 0. Execution starts the next cycle.
- Precedence and timing:
  - reset > load_en > execution.
  - Reset mid-load aborts the load and clears imem.
  - Register write and pc update take effect in the same cycle; reading a register written by the previous instruction sees the new value.

Decomposition:
- Package nand_proc_pkg holds:
  - OP_NAND/OP_BRANCH constants.
  - Register-map base functions: in_base, out_base, int_base.
  - Field-extract functions parametrised by ADDR_W.
- Sub-module nand_proc_loader holds:
  - bit_cnt, wr_ptr, the shift word and overflow logic.
  - Outputs: wr_en, wr_addr, wr_data.

Test Plan:
- Defaults, load 1 instr NAND(srcA=0, srcB=0, dst=out0), then end load → cycle 1: out_reg[0]=0, pc=1; cycle 2: fetch zero word → halted=1, pc=1.
- WORD_W=4, in0=4'hA, in1=4'h6, prog NAND(in0,in1→int0); NAND(int0,int0→out0); HALT → out0=4'h2, halted=1 at pc=2.
- Countdown loop: branch backward M=1 on int0 after toggling int0 → pc alternates 0,1,0,1 until int0=0, then falls through to pc=2.
- IMEM_DEPTH=4, stream 5 full instructions → load_overflow=1, imem[0..3] hold the first four; new load_en rise clears overflow.
- Drop load_en after INSTR_W-3 bits of instr 1 → imem[1] unchanged, pc=0, halted=0.
- Assert reset mid-run with out0=1 → next cycle out_reg=0, pc=0, halted=0; writes to addr 0 or 1 never change any register.

Source files
------------

// File: rtl/nand_proc_pkg.sv
// Shared opcode encoding, register-map layout and instruction field extraction
// for the parametrised NAND/branch processor.
package nand_proc_pkg;

  typedef enum logic {
    OP_BRANCH = 1'b0,
    OP_NAND   = 1'b1
  } op_e;

  function automatic int unsigned in_base();
    return 1;
  endfunction

  function automatic int unsigned out_base(input int unsigned num_in);
    return 1 + num_in;
  endfunction

  function automatic int unsigned int_base(input int unsigned num_in, input int unsigned num_out);
    return 1 + num_in + num_out;
  endfunction

  function automatic logic [63:0] field_mask(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int unsigned f_src_a(input logic [63:0] instr, input int unsigned addr_w);
    return 32'((instr >> 1) & field_mask(addr_w));
  endfunction

  function automatic int unsigned f_src_b(input logic [63:0] instr, input int unsigned addr_w);
    return 32'((instr >> (addr_w + 1)) & field_mask(addr_w));
  endfunction

  function automatic int unsigned f_dst(input logic [63:0] instr, input int unsigned addr_w);
    return 32'((instr >> (2 * addr_w + 1)) & field_mask(addr_w));
  endfunction

  function automatic logic f_dir(input logic [63:0] instr, input int unsigned addr_w);
    return instr[3 * addr_w];
  endfunction

  function automatic int unsigned f_mag(input logic [63:0] instr, input int unsigned addr_w);
    return 32'((instr >> (addr_w + 1)) & field_mask(2 * addr_w - 1));
  endfunction

endpackage

// File: rtl/nand_proc_loader.sv
// Serial instruction loader: assembles LSB-first bit stream into words and
// emits one imem write per completed word, flagging overflow past IMEM_DEPTH.
module nand_proc_loader #(
  parameter int unsigned INSTR_W    = 13,
  parameter int unsigned IMEM_DEPTH = 1000,
  parameter int unsigned PC_W       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic               load_bit,
  output logic               wr_en,
  output logic [PC_W-1:0]    wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               load_done,
  output logic               load_overflow
);

  localparam int unsigned CNT_W = $clog2(INSTR_W + 1);

  logic               load_q;
  logic               rise;
  logic               full;
  logic               accept;
  logic               last;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt_eff;
  logic [PC_W:0]      wr_ptr;
  logic [PC_W:0]      ptr_eff;
  logic [INSTR_W-1:0] shift_q;
  logic [INSTR_W-1:0] shift_nxt;

  // On the rising edge the counters read as zero so a bit arriving in that
  // same cycle lands at imem[0] bit 0.
  always_comb begin
    rise      = load_en & ~load_q;
    load_done = ~load_en & load_q;
    cnt_eff   = rise ? '0 : bit_cnt;
    ptr_eff   = rise ? '0 : wr_ptr;
    full      = (ptr_eff == (PC_W + 1)'(IMEM_DEPTH));
    accept    = load_en & load_valid & ~full;
    last      = (cnt_eff == CNT_W'(INSTR_W - 1));
    shift_nxt = shift_q;
    shift_nxt[cnt_eff] = load_bit;
    wr_en     = accept & last;
    wr_addr   = ptr_eff[PC_W-1:0];
    wr_data   = shift_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q        <= 1'b0;
      bit_cnt       <= '0;
      wr_ptr        <= '0;
      shift_q       <= '0;
      load_overflow <= 1'b0;
    end else begin
      load_q <= load_en;
      if (load_en) begin
        bit_cnt <= cnt_eff;
        wr_ptr  <= ptr_eff;
        if (rise)
          load_overflow <= 1'b0;
        if (load_valid && full)
          load_overflow <= 1'b1;
        if (accept) begin
          shift_q <= shift_nxt;
          if (last) begin
            bit_cnt <= '0;
            wr_ptr  <= ptr_eff + 1'b1;
          end else begin
            bit_cnt <= cnt_eff + 1'b1;
          end
        end
      end else if (load_q) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/nand_processor_gen.sv
// Word-wide NAND/branch processor with serial program loader, HALT encoding
// and zero-fetch beyond the end of instruction memory.
module nand_processor_gen
  import nand_proc_pkg::*;
#(
  parameter int unsigned WORD_W     = 1,
  parameter int unsigned NUM_IN     = 2,
  parameter int unsigned NUM_OUT    = 7,
  parameter int unsigned NUM_INT    = 6,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned IMEM_DEPTH = 1000,
  parameter int unsigned PC_W       = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN*WORD_W-1:0]  in_reg,
  input  logic                      load_en,
  input  logic                      load_valid,
  input  logic                      load_bit,
  output logic [NUM_OUT*WORD_W-1:0] out_reg,
  output logic [PC_W-1:0]           pc,
  output logic                      halted,
  output logic                      load_overflow
);

  localparam int unsigned INSTR_W = 1 + 3 * ADDR_W;

  logic [WORD_W-1:0]  out_q [NUM_OUT];
  logic [WORD_W-1:0]  int_q [NUM_INT];
  logic [INSTR_W-1:0] imem  [IMEM_DEPTH];

  logic               wr_en;
  logic [PC_W-1:0]    wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               load_done;

  logic [INSTR_W-1:0] instr;
  logic [63:0]        instr_x;
  int unsigned        src_a, src_b, dst, mag_full;
  logic               dir;
  logic [PC_W-1:0]    mag;
  logic [WORD_W-1:0]  a_val, b_val, nand_val;

  nand_proc_loader #(
    .INSTR_W    (INSTR_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .PC_W       (PC_W)
  ) u_loader (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_valid    (load_valid),
    .load_bit      (load_bit),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .load_done     (load_done),
    .load_overflow (load_overflow)
  );

  function automatic logic [WORD_W-1:0] rd(input int unsigned addr);
    logic [WORD_W-1:0] v;
    v = '0;
    if (addr == 0)
      v = '1;
    for (int unsigned k = 0; k < NUM_IN; k++)
      if (addr == in_base() + k) v = in_reg[k*WORD_W +: WORD_W];
    for (int unsigned k = 0; k < NUM_OUT; k++)
      if (addr == out_base(NUM_IN) + k) v = out_q[k];
    for (int unsigned k = 0; k < NUM_INT; k++)
      if (addr == int_base(NUM_IN, NUM_OUT) + k) v = int_q[k];
    return v;
  endfunction

  // A fetch past the end of memory yields the zero word, which decodes as HALT.
  always_comb begin
    instr = '0;
    if (32'(pc) < IMEM_DEPTH)
      instr = imem[pc];
    instr_x  = 64'(instr);
    src_a    = f_src_a(instr_x, ADDR_W);
    src_b    = f_src_b(instr_x, ADDR_W);
    dst      = f_dst(instr_x, ADDR_W);
    dir      = f_dir(instr_x, ADDR_W);
    mag_full = f_mag(instr_x, ADDR_W);
    mag      = PC_W'(mag_full);
    a_val    = rd(src_a);
    b_val    = rd(src_b);
    nand_val = ~(a_val & b_val);
  end

  always_comb begin
    out_reg = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      out_reg[k*WORD_W +: WORD_W] = out_q[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
      out_q  <= '{default: '0};
      int_q  <= '{default: '0};
      imem   <= '{default: '0};
    end else if (load_en) begin
      if (wr_en)
        imem[wr_addr] <= wr_data;
    end else if (load_done) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (op_e'(instr[0]) == OP_NAND) begin
        for (int unsigned k = 0; k < NUM_OUT; k++)
          if (dst == out_base(NUM_IN) + k) out_q[k] <= nand_val;
        for (int unsigned k = 0; k < NUM_INT; k++)
          if (dst == int_base(NUM_IN, NUM_OUT) + k) int_q[k] <= nand_val;
        pc <= pc + 1'b1;
      end else if (a_val != '0) begin
        if (mag_full == 0)
          halted <= 1'b1;
        else
          pc <= dir ? pc - mag : pc + mag;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nand_processor_gen.sv
// Scenario bench for nand_processor_gen (WORD_W=4, IMEM_DEPTH=4): per-cycle
// expected pc/halted/out_reg are queued per scenario and compared each cycle.
module tb_nand_processor_gen;

  localparam int unsigned WORD_W = 4;
  localparam int unsigned NUM_IN = 2;
  localparam int unsigned NUM_OUT = 7;
  localparam int unsigned PC_W = 10;
  localparam int unsigned OUT_W = NUM_OUT * WORD_W;

  localparam int A_CONST = 0, A_IN0 = 1, A_IN1 = 2;
  localparam int A_OUT0 = 3, A_OUT1 = 4, A_OUT2 = 5, A_INT0 = 10;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_IN*WORD_W-1:0] in_reg = '0;
  logic                     load_en = 1'b0;
  logic                     load_valid = 1'b0;
  logic                     load_bit = 1'b0;
  logic [OUT_W-1:0]         out_reg;
  logic [PC_W-1:0]          pc;
  logic                     halted;
  logic                     load_overflow;

  nand_processor_gen #(
    .WORD_W     (WORD_W),
    .IMEM_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_reg        (in_reg),
    .load_en       (load_en),
    .load_valid    (load_valid),
    .load_bit      (load_bit),
    .out_reg       (out_reg),
    .pc            (pc),
    .halted        (halted),
    .load_overflow (load_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [OUT_W-1:0] outv;
  } exp_t;

  exp_t        sb[$];
  logic [12:0] prog[$];
  logic [12:0] partial_word;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [12:0] enc_nand(int a, int b, int d);
    return {4'(d), 4'(b), 4'(a), 1'b1};
  endfunction

  function automatic logic [12:0] enc_br(int a, bit dir, int m);
    return {dir, 7'(m), 4'(a), 1'b0};
  endfunction

  function automatic void push(int p, bit h, logic [OUT_W-1:0] o);
    exp_t e;
    e.pc = PC_W'(p);
    e.halted = h;
    e.outv = o;
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams prog[] then `partial` bits of partial_word, then drops load_en.
  task automatic do_load(input int partial);
    load_en = 1'b1;
    foreach (prog[i]) begin
      for (int b = 0; b < 13; b++) begin
        load_valid = 1'b1;
        load_bit = prog[i][b];
        @(negedge clk);
      end
    end
    for (int b = 0; b < partial; b++) begin
      load_valid = 1'b1;
      load_bit = partial_word[b];
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_bit = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_reg !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out_reg); end
    n_checks++;
    if (pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_checks++;
    if (load_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", load_overflow); end
    reset = 1'b0;
  endtask

  task automatic test_single_nand();
    exp_t e;
    do_reset();
    prog = '{enc_nand(A_CONST, A_CONST, A_OUT0)};
    do_load(0);
    n_checks++;
    if (pc !== '0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL single_start: got pc=%0d halted=%b expected pc=0 halted=0", pc, halted);
    end
    push(1, 0, '0); push(1, 1, '0); push(1, 1, '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL single_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (halted !== e.halted) begin n_fail++; $display("FAIL single_halted: got %b expected %b", halted, e.halted); end
      n_checks++;
      if (out_reg !== e.outv) begin n_fail++; $display("FAIL single_out: got %h expected %h", out_reg, e.outv); end
    end
  endtask

  task automatic test_word_nand();
    exp_t e;
    do_reset();
    in_reg = {4'h6, 4'hA};
    prog = '{enc_nand(A_IN0, A_IN1, A_INT0), enc_nand(A_INT0, A_INT0, A_OUT0), enc_br(A_CONST, 0, 0)};
    do_load(0);
    push(1, 0, 28'h0); push(2, 0, 28'h2); push(2, 1, 28'h2); push(2, 1, 28'h2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL word_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (halted !== e.halted) begin n_fail++; $display("FAIL word_halted: got %b expected %b", halted, e.halted); end
      n_checks++;
      if (out_reg !== e.outv) begin n_fail++; $display("FAIL word_out: got %h expected %h", out_reg, e.outv); end
    end
  endtask

  task automatic test_countdown();
    exp_t e;
    do_reset();
    prog = '{enc_nand(A_INT0, A_INT0, A_INT0), enc_br(A_INT0, 1, 1), enc_br(A_CONST, 0, 0)};
    do_load(0);
    push(1, 0, '0); push(0, 0, '0); push(1, 0, '0); push(2, 0, '0); push(2, 1, '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL loop_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (halted !== e.halted) begin n_fail++; $display("FAIL loop_halted: got %b expected %b", halted, e.halted); end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    do_reset();
    in_reg = {4'h6, 4'hA};
    prog = '{enc_nand(A_IN0, A_IN0, A_OUT0), enc_nand(A_IN1, A_IN1, A_OUT1),
             enc_nand(A_CONST, A_CONST, A_INT0), enc_nand(A_CONST, A_INT0, A_OUT2),
             enc_nand(A_CONST, A_CONST, A_OUT0)};
    do_load(0);
    n_checks++;
    if (load_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", load_overflow); end
    push(1, 0, 28'h005); push(2, 0, 28'h095); push(3, 0, 28'h095);
    push(4, 0, 28'hF95); push(4, 1, 28'hF95);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL ovf_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (halted !== e.halted) begin n_fail++; $display("FAIL ovf_halted: got %b expected %b", halted, e.halted); end
      n_checks++;
      if (out_reg !== e.outv) begin n_fail++; $display("FAIL ovf_out: got %h expected %h", out_reg, e.outv); end
    end
    n_checks++;
    if (load_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", load_overflow); end
  endtask

  // Continues from test_overflow's imem contents without a reset.
  task automatic test_partial_load();
    exp_t e;
    load_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", load_overflow); end
    prog = '{enc_nand(A_CONST, A_CONST, A_OUT1)};
    partial_word = enc_br(A_CONST, 0, 0);
    do_load(10);
    n_checks++;
    if (pc !== '0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL partial_start: got pc=%0d halted=%b expected pc=0 halted=0", pc, halted);
    end
    push(1, 0, 28'hF05); push(2, 0, 28'hF95); push(3, 0, 28'hF95);
    push(4, 0, 28'hF95); push(4, 1, 28'hF95);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL partial_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (halted !== e.halted) begin n_fail++; $display("FAIL partial_halted: got %b expected %b", halted, e.halted); end
      n_checks++;
      if (out_reg !== e.outv) begin n_fail++; $display("FAIL partial_out: got %h expected %h", out_reg, e.outv); end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    do_reset();
    in_reg = {4'h6, 4'hE};
    prog = '{enc_nand(A_CONST, A_CONST, A_CONST), enc_nand(A_CONST, A_CONST, A_IN0),
             enc_nand(A_CONST, A_IN0, A_OUT0), enc_nand(A_IN0, A_IN0, A_OUT1)};
    do_load(0);
    push(1, 0, 28'h0); push(2, 0, 28'h0); push(3, 0, 28'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL midrst_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (out_reg !== e.outv) begin n_fail++; $display("FAIL midrst_out: got %h expected %h", out_reg, e.outv); end
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_reg !== '0 || pc !== '0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: got out=%h pc=%0d halted=%b expected 0/0/0", out_reg, pc, halted);
    end
    reset = 1'b0;
    push(0, 1, '0); push(0, 1, '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      n_checks++;
      if (pc !== e.pc) begin n_fail++; $display("FAIL empty_pc: got %0d expected %0d", pc, e.pc); end
      n_checks++;
      if (halted !== e.halted) begin n_fail++; $display("FAIL empty_halted: got %b expected %b", halted, e.halted); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_nand();
    test_word_nand();
    test_countdown();
    test_overflow();
    test_partial_load();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
